// File: rtl/motion_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : motion_arbiter
//  Description : Shares the car's motion actuator (forward, backward,
//                rotate-left, rotate-right) between the manual keys, the
//                semi-auto controller and the auto controller. Semi/auto turn
//                triggers become timed in-place rotations with an is_turning
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module motion_arbiter #(
    parameter int TURN_90 = 450,
    parameter int SETTLE  = 10,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       man_fwd,
    input  logic       man_back,
    input  logic       man_left,
    input  logic       man_right,
    input  logic       semi_fwd,
    input  logic       semi_tl,
    input  logic       semi_tr,
    input  logic       semi_tb,
    input  logic       auto_fwd,
    input  logic       auto_tl,
    input  logic       auto_tr,
    input  logic       auto_tb,
    output logic       move_forward,
    output logic       move_backward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       is_turning,
    output logic [1:0] owner
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_TURN   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SWITCH = 3'd4
    } state_t;

    localparam logic [1:0] C_OWN_MAN  = 2'b00;
    localparam logic [1:0] C_OWN_SEMI = 2'b01;
    localparam logic [1:0] C_OWN_AUTO = 2'b10;

    // Last counter value of each timed phase (counter starts at 0 on entry)
    localparam logic [CNT_W-1:0] C_LAST_90  = CNT_W'(TURN_90 - 1);
    localparam logic [CNT_W-1:0] C_LAST_180 = CNT_W'(2 * TURN_90 - 1);
    localparam logic [CNT_W-1:0] C_LAST_SET = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

    state_t           state_q;
    logic [1:0]       owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             back_q;
    logic [2:0]       semi_prev_q;
    logic [2:0]       auto_prev_q;
    logic             fwd_q, bwd_q, tl_q, tr_q, busy_q;

    logic             drv_fwd_d, drv_bwd_d, drv_tl_d, drv_tr_d;
    logic [2:0]       trig_d, prev_d, edge_d;
    logic             turn_done_d;

    // Free-driving decode of the current owner's level requests
    always_comb begin
        drv_fwd_d = 1'b0;
        drv_bwd_d = 1'b0;
        drv_tl_d  = 1'b0;
        drv_tr_d  = 1'b0;
        case (owner_q)
            C_OWN_MAN: begin
                drv_fwd_d = man_fwd & ~man_back;
                drv_bwd_d = man_back & ~man_fwd;
                drv_tl_d  = man_left & ~man_right;
                drv_tr_d  = man_right & ~man_left;
            end
            C_OWN_SEMI: drv_fwd_d = semi_fwd;
            C_OWN_AUTO: drv_fwd_d = auto_fwd;
            default:    ;
        endcase
    end

    // Rising edges of the owner's {back, right, left} triggers; non-owner ignored
    always_comb begin
        trig_d = 3'b000;
        prev_d = 3'b000;
        if (owner_q == C_OWN_SEMI) begin
            trig_d = {semi_tb, semi_tr, semi_tl};
            prev_d = semi_prev_q;
        end else if (owner_q == C_OWN_AUTO) begin
            trig_d = {auto_tb, auto_tr, auto_tl};
            prev_d = auto_prev_q;
        end
        edge_d      = trig_d & ~prev_d;
        turn_done_d = (cnt_q == (back_q ? C_LAST_180 : C_LAST_90));
    end

    // Arbitration FSM with registered actuator outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= C_OWN_MAN;
            cnt_q       <= '0;
            back_q      <= 1'b0;
            semi_prev_q <= 3'b000;
            auto_prev_q <= 3'b000;
            fwd_q       <= 1'b0;
            bwd_q       <= 1'b0;
            tl_q        <= 1'b0;
            tr_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Edge history always tracks both requesters so a fresh owner sees no stale edge
            semi_prev_q <= {semi_tb, semi_tr, semi_tl};
            auto_prev_q <= {auto_tb, auto_tr, auto_tl};
            case (state_q)
                ST_IDLE, ST_DRIVE, ST_SWITCH: begin
                    if (mode != owner_q) begin
                        state_q <= ST_SWITCH;
                        owner_q <= mode;
                        {fwd_q, bwd_q, tl_q, tr_q, busy_q} <= 5'b0;
                    end else if ((state_q != ST_SWITCH) && (edge_d != 3'b000)) begin
                        state_q <= ST_TURN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        fwd_q   <= 1'b0;
                        bwd_q   <= 1'b0;
                        tl_q    <= edge_d[0];
                        tr_q    <= ~edge_d[0];
                        back_q  <= ~edge_d[0] & ~edge_d[1];
                    end else begin
                        fwd_q   <= drv_fwd_d;
                        bwd_q   <= drv_bwd_d;
                        tl_q    <= drv_tl_d;
                        tr_q    <= drv_tr_d;
                        busy_q  <= 1'b0;
                        state_q <= (drv_fwd_d | drv_bwd_d | drv_tl_d | drv_tr_d) ? ST_DRIVE : ST_IDLE;
                    end
                end
                ST_TURN: begin
                    if (turn_done_d) begin
                        {fwd_q, bwd_q, tl_q, tr_q} <= 4'b0;
                        cnt_q <= '0;
                        if (SETTLE == 0) begin
                            busy_q  <= 1'b0;
                            owner_q <= mode;
                            state_q <= (mode != owner_q) ? ST_SWITCH : ST_IDLE;
                        end else begin
                            state_q <= ST_SETTLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == C_LAST_SET) begin
                        busy_q  <= 1'b0;
                        owner_q <= mode;
                        state_q <= (mode != owner_q) ? ST_SWITCH : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    {fwd_q, bwd_q, tl_q, tr_q, busy_q} <= 5'b0;
                end
            endcase
        end
    end

    assign move_forward  = fwd_q;
    assign move_backward = bwd_q;
    assign turn_left     = tl_q;
    assign turn_right    = tr_q;
    assign is_turning    = busy_q;
    assign owner         = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_motion_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motion_arbiter
//  Description : Directed self-checking bench for motion_arbiter
//                (TURN_90 = 8, SETTLE = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motion_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       man_fwd, man_back, man_left, man_right;
    logic       semi_fwd, semi_tl, semi_tr, semi_tb;
    logic       auto_fwd, auto_tl, auto_tr, auto_tb;
    logic       move_forward, move_backward, turn_left, turn_right, is_turning;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    motion_arbiter #(.TURN_90(8), .SETTLE(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .man_fwd(man_fwd), .man_back(man_back), .man_left(man_left), .man_right(man_right),
        .semi_fwd(semi_fwd), .semi_tl(semi_tl), .semi_tr(semi_tr), .semi_tb(semi_tb),
        .auto_fwd(auto_fwd), .auto_tl(auto_tl), .auto_tr(auto_tr), .auto_tb(auto_tb),
        .move_forward(move_forward), .move_backward(move_backward),
        .turn_left(turn_left), .turn_right(turn_right),
        .is_turning(is_turning), .owner(owner)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {owner[1:0], is_turning, fwd, back, left, right}
    function automatic logic [6:0] ev(input logic [1:0] own, input logic busy,
                                      input logic f, input logic b,
                                      input logic l, input logic r);
        return {own, busy, f, b, l, r};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {owner, is_turning, move_forward, move_backward, turn_left, turn_right};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Actuator invariants on every cycle outside reset
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert ({move_forward & move_backward, turn_left & turn_right,
                     (turn_left | turn_right) & is_turning & (move_forward | move_backward)} === 3'b000)
            else begin
                errors++;
                $error("FAIL invariant observed=%b%b%b%b expected=no_conflict",
                       move_forward, move_backward, turn_left, turn_right);
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 2'b00;
        {man_fwd, man_back, man_left, man_right} = 4'b0;
        {semi_fwd, semi_tl, semi_tr, semi_tb}    = 4'b0;
        {auto_fwd, auto_tl, auto_tr, auto_tb}    = 4'b0;

        // Reset and manual decode
        step(1); chk("reset_1", ev(2'b00, 0, 0, 0, 0, 0));
        man_fwd = 1'b1;
        step(2); chk("reset_3", ev(2'b00, 0, 0, 0, 0, 0));
        rst = 1'b0;
        step(1); chk("man_fwd", ev(2'b00, 0, 1, 0, 0, 0));
        man_back = 1'b1;
        step(1); chk("man_fwd_back", ev(2'b00, 0, 0, 0, 0, 0));
        man_left = 1'b1;
        step(1); chk("man_left", ev(2'b00, 0, 0, 0, 1, 0));
        man_right = 1'b1;
        step(1); chk("man_left_right", ev(2'b00, 0, 0, 0, 0, 0));
        {man_fwd, man_back, man_left, man_right} = 4'b0;

        // Semi left turn
        mode = 2'b01;
        step(1); chk("semi_switch", ev(2'b01, 0, 0, 0, 0, 0));
        semi_fwd = 1'b1;
        step(1); chk("semi_fwd", ev(2'b01, 0, 1, 0, 0, 0));
        semi_tl = 1'b1;
        step(1); chk("semi_tl_start", ev(2'b01, 1, 0, 0, 1, 0));
        for (int i = 1; i < 8; i++) begin
            if (i == 5) semi_tl = 1'b0;
            step(1); chk("semi_tl_hold", ev(2'b01, 1, 0, 0, 1, 0));
        end
        step(1); chk("semi_settle0", ev(2'b01, 1, 0, 0, 0, 0));
        step(1); chk("semi_settle1", ev(2'b01, 1, 0, 0, 0, 0));
        step(1); chk("semi_release", ev(2'b01, 0, 0, 0, 0, 0));
        step(1); chk("semi_fwd_resume", ev(2'b01, 0, 1, 0, 0, 0));
        semi_fwd = 1'b0;

        // Auto turn-back: 16 cycles of turn_right
        mode = 2'b10;
        step(1); chk("auto_switch", ev(2'b10, 0, 0, 0, 0, 0));
        step(1); chk("auto_idle", ev(2'b10, 0, 0, 0, 0, 0));
        auto_tb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1); chk("auto_tb_turn", ev(2'b10, 1, 0, 0, 0, 1));
        end
        auto_tb = 1'b0;
        step(1); chk("auto_tb_settle0", ev(2'b10, 1, 0, 0, 0, 0));
        step(1); chk("auto_tb_settle1", ev(2'b10, 1, 0, 0, 0, 0));
        step(1); chk("auto_tb_done", ev(2'b10, 0, 0, 0, 0, 0));

        // Simultaneous left+right -> left; new right edge mid-turn discarded
        auto_tl = 1'b1; auto_tr = 1'b1;
        step(1); chk("auto_prio_left", ev(2'b10, 1, 0, 0, 1, 0));
        for (int i = 1; i < 8; i++) begin
            if (i == 2) auto_tr = 1'b0;
            if (i == 4) auto_tr = 1'b1;
            step(1); chk("auto_prio_hold", ev(2'b10, 1, 0, 0, 1, 0));
        end
        step(1); chk("auto_prio_settle0", ev(2'b10, 1, 0, 0, 0, 0));
        step(1); chk("auto_prio_settle1", ev(2'b10, 1, 0, 0, 0, 0));
        step(1); chk("auto_no_requeue0", ev(2'b10, 0, 0, 0, 0, 0));
        step(1); chk("auto_no_requeue1", ev(2'b10, 0, 0, 0, 0, 0));
        auto_tl = 1'b0; auto_tr = 1'b0;

        // Mode change mid-turn held until settle completes
        mode = 2'b01;
        step(2); chk("mid_setup", ev(2'b01, 0, 0, 0, 0, 0));
        semi_tl = 1'b1;
        step(1); chk("mid_turn0", ev(2'b01, 1, 0, 0, 1, 0));
        step(2); chk("mid_turn2", ev(2'b01, 1, 0, 0, 1, 0));
        mode = 2'b00; man_fwd = 1'b1; semi_tl = 1'b0;
        for (int i = 3; i < 8; i++) begin
            step(1); chk("mid_turn_hold", ev(2'b01, 1, 0, 0, 1, 0));
        end
        step(1); chk("mid_settle0", ev(2'b01, 1, 0, 0, 0, 0));
        step(1); chk("mid_settle1", ev(2'b01, 1, 0, 0, 0, 0));
        step(1); chk("mid_switch", ev(2'b00, 0, 0, 0, 0, 0));
        step(1); chk("mid_manual", ev(2'b00, 0, 1, 0, 0, 0));
        man_fwd = 1'b0;

        // Isolation: auto owns, semi toggles
        mode = 2'b10; semi_fwd = 1'b1;
        step(2); chk("iso_setup", ev(2'b10, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            semi_tl = ~semi_tl;
            step(1); chk("iso_semi_toggle", ev(2'b10, 0, 0, 0, 0, 0));
        end
        semi_tl = 1'b0; semi_fwd = 1'b0;

        // Off: every request asserted, nothing moves
        mode = 2'b11;
        {man_fwd, man_back, man_left, man_right} = 4'b1010;
        {semi_fwd, semi_tl, semi_tr, semi_tb}    = 4'b1111;
        {auto_fwd, auto_tl, auto_tr, auto_tb}    = 4'b1111;
        step(1); chk("off_switch", ev(2'b11, 0, 0, 0, 0, 0));
        step(1); chk("off_hold0", ev(2'b11, 0, 0, 0, 0, 0));
        step(1); chk("off_hold1", ev(2'b11, 0, 0, 0, 0, 0));
        {man_fwd, man_back, man_left, man_right} = 4'b0;
        {semi_fwd, semi_tl, semi_tr, semi_tb}    = 4'b0;
        {auto_fwd, auto_tl, auto_tr, auto_tb}    = 4'b0;

        // Reset mid-turn, then a full fresh turn
        mode = 2'b01;
        step(2); chk("rst_setup", ev(2'b01, 0, 0, 0, 0, 0));
        semi_tl = 1'b1;
        step(1); chk("rst_turn0", ev(2'b01, 1, 0, 0, 1, 0));
        step(3); chk("rst_turn3", ev(2'b01, 1, 0, 0, 1, 0));
        rst = 1'b1;
        step(1); chk("rst_abort", ev(2'b00, 0, 0, 0, 0, 0));
        rst = 1'b0; semi_tl = 1'b0;
        step(1); chk("rst_reswitch", ev(2'b01, 0, 0, 0, 0, 0));
        step(1); chk("rst_idle", ev(2'b01, 0, 0, 0, 0, 0));
        semi_tl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1); chk("rst_full_turn", ev(2'b01, 1, 0, 0, 1, 0));
        end
        step(1); chk("rst_full_settle", ev(2'b01, 1, 0, 0, 0, 0));
        semi_tl = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
